// File: rtl/cla_serial_subtractor.sv
// Nibble-serial A - B - BIN using a 4-bit borrow-lookahead slice; result after NIB busy cycles.
// One operation in flight; result held in DONE until out_ready, inputs ignored meanwhile.
module cla_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state;
  logic [NIB-1:0][3:0] r_a;
  logic [NIB-1:0][3:0] r_b;
  logic [NIB-1:0][3:0] r_diff;
  logic [IW-1:0]       r_idx;
  logic                r_borrow;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_bout;
  logic                r_ovf;

  logic [3:0] w_as, w_bs, w_g, w_p, w_c, w_sum;
  logic       w_c4;
  logic       w_ovf;

  // Subtraction as A + ~B + carry, where carry-in is the inverted borrow.
  always_comb begin
    w_as  = r_a[r_idx];
    w_bs  = r_b[r_idx];
    w_g   = w_as & ~w_bs;
    w_p   = w_as ^ ~w_bs;
    w_c[0] = ~r_borrow;
    w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_c4  = w_g[3] | (w_p[3] & w_c[3]);
    w_sum = w_p ^ w_c;
    w_ovf = (r_a[NIB-1][3] != r_b[NIB-1][3]) && (w_sum[3] != r_a[NIB-1][3]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_idx       <= '0;
      r_borrow    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_borrow   <= bin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_diff[r_idx] <= w_sum;
          r_borrow      <= ~w_c4;
          r_idx         <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_idx       <= '0;
            r_bout      <= ~w_c4;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule
